// File: rtl/inst_fetch_if.sv
// Bus between the fetch stage, its instruction memory, the control stage and the redirect logic.
// The fetch stage takes the master side and the surrounding environment takes the slave side.
interface inst_fetch_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       stall;
    logic       L_PC;
    logic       S11;
    logic       S10;
    logic [7:0] rd_base;
    logic [7:0] rd_od;
    logic [7:0] rd_ret;
    logic [7:0] opcode_out;
    logic [7:0] operand_out;
    logic [7:0] instr_pc;
    logic       valid_out;

    modport master (
        output imem_addr, opcode_out, operand_out, instr_pc, valid_out,
        input  imem_data, stall, L_PC, S11, S10, rd_base, rd_od, rd_ret
    );

    modport slave (
        input  imem_addr, opcode_out, operand_out, instr_pc, valid_out,
        output imem_data, stall, L_PC, S11, S10, rd_base, rd_od, rd_ret
    );
endinterface

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles 1- and 2-byte instructions from an 8-bit memory,
// with PC redirect (relative, absolute or return) that takes priority over a downstream stall.
module inst_fetch (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);

    typedef enum logic {FETCH_OP, FETCH_OD} state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] held_op;
    logic [7:0] held_pc;

    logic       redirect;
    logic [7:0] redirect_pc;
    logic       two_byte;

    function automatic logic is_two_byte(input logic [7:0] op);
        logic r;
        casez (op)
            8'h03, 8'h04, 8'h05, 8'h06,
            8'b0000_1???, 8'b0010_1???, 8'b0011_????, 8'b0101_1???: r = 1'b1;
            default: r = op[7] && (op[6:4] != 3'b111) && op[3];
        endcase
        return r;
    endfunction

    assign bus.imem_addr = pc;
    assign two_byte      = is_two_byte(bus.imem_data);

    // Select 00 is not a redirect at all, so it falls through to stall/normal fetch.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
        redirect    = 1'b0;
        redirect_pc = pc;
        if (bus.L_PC) begin
            unique case ({bus.S11, bus.S10})
                2'b01: begin redirect = 1'b1; redirect_pc = bus.rd_base + bus.rd_od; end
                2'b11: begin redirect = 1'b1; redirect_pc = bus.rd_od;               end
                2'b10: begin redirect = 1'b1; redirect_pc = bus.rd_ret;              end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state           <= FETCH_OP;
            pc              <= 8'h00;
            held_op         <= 8'h00;
            held_pc         <= 8'h00;
            bus.opcode_out  <= 8'h00;
            bus.operand_out <= 8'h00;
            bus.instr_pc    <= 8'h00;
            bus.valid_out   <= 1'b0;
        end else if (redirect) begin
            state           <= FETCH_OP;
            pc              <= redirect_pc;
            held_op         <= 8'h00;
            bus.opcode_out  <= 8'h00;
            bus.operand_out <= 8'h00;
            bus.valid_out   <= 1'b0;
        end else if (!bus.stall) begin
            pc <= pc + 8'h01;
            unique case (state)
                FETCH_OP: begin
                    if (two_byte) begin
                        state           <= FETCH_OD;
                        held_op         <= bus.imem_data;
                        held_pc         <= pc;
                        bus.opcode_out  <= 8'h00;
                        bus.operand_out <= 8'h00;
                        bus.valid_out   <= 1'b0;
                    end else begin
                        bus.opcode_out  <= bus.imem_data;
                        bus.operand_out <= 8'h00;
                        bus.instr_pc    <= pc;
                        bus.valid_out   <= 1'b1;
                    end
                end
                FETCH_OD: begin
                    state           <= FETCH_OP;
                    bus.opcode_out  <= held_op;
                    bus.operand_out <= bus.imem_data;
                    bus.instr_pc    <= held_pc;
                    bus.valid_out   <= 1'b1;
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: each scenario queues the expected per-edge outputs,
// and every clock edge pops one entry and compares it with the DUT.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] mem [256];

    inst_fetch_if ifc ();

    inst_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    assign ifc.imem_data = mem[ifc.imem_addr];

    typedef struct packed {
        logic       valid;
        logic [7:0] opc;
        logic [7:0] opd;
        logic [7:0] ipc;
        logic [7:0] addr;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic push(input logic v, input logic [7:0] opc, input logic [7:0] opd,
                        input logic [7:0] ipc, input logic [7:0] addr);
        exp_t e;
        e.valid = v; e.opc = opc; e.opd = opd; e.ipc = ipc; e.addr = addr;
        sb.push_back(e);
    endtask

    // Advance one edge, then pop the oldest expectation and compare it with the DUT.
    // instr_pc is only meaningful on a valid output, so bubbles ignore it.
    task automatic step(input string name);
        exp_t e;
        logic ok;
        @(posedge clk);
        #1;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty at %0t", name, $time);
        end else begin
            e  = sb.pop_front();
            ok = (ifc.valid_out === e.valid) && (ifc.opcode_out === e.opc) &&
                 (ifc.operand_out === e.opd) && (ifc.imem_addr === e.addr) &&
                 (!e.valid || ifc.instr_pc === e.ipc);
            if (ok) passed++;
            else $display("FAIL %s: got v=%b op=%h od=%h pc=%h addr=%h, want v=%b op=%h od=%h pc=%h addr=%h",
                          name, ifc.valid_out, ifc.opcode_out, ifc.operand_out, ifc.instr_pc,
                          ifc.imem_addr, e.valid, e.opc, e.opd, e.ipc, e.addr);
        end
    endtask

    task automatic set_redirect(input logic l, input logic [1:0] sel, input logic [7:0] base,
                                input logic [7:0] od, input logic [7:0] ret);
        ifc.L_PC = l; {ifc.S11, ifc.S10} = sel;
        ifc.rd_base = base; ifc.rd_od = od; ifc.rd_ret = ret;
    endtask

    task automatic test_reset();
        total++;
        if ({ifc.valid_out, ifc.opcode_out, ifc.operand_out, ifc.instr_pc, ifc.imem_addr} !== 33'h0)
            $display("FAIL reset_state: got v=%b op=%h od=%h pc=%h addr=%h, want all zero",
                     ifc.valid_out, ifc.opcode_out, ifc.operand_out, ifc.instr_pc, ifc.imem_addr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        push(1, 8'h00, 8'h00, 8'h00, 8'h01); step("first_fetch");
        push(1, 8'h41, 8'h00, 8'h01, 8'h02); step("second_fetch");
    endtask

    task automatic test_two_byte();
        push(0, 8'h00, 8'h00, 8'h00, 8'h03); step("two_byte_bubble");
        push(1, 8'h5B, 8'h7F, 8'h02, 8'h04); step("two_byte_emit");
    endtask

    task automatic test_stall();
        push(1, 8'h41, 8'h00, 8'h04, 8'h05); step("pre_stall");
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1, 8'h41, 8'h00, 8'h04, 8'h05); step("stall_hold");
        end
        ifc.stall = 1'b0;
        push(1, 8'h42, 8'h00, 8'h05, 8'h06); step("post_stall");
    endtask

    task automatic test_redirect();
        push(0, 8'h00, 8'h00, 8'h00, 8'h07); step("od_enter");
        set_redirect(1, 2'b11, 8'h00, 8'h40, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h40); step("abs_in_od");
        set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
        push(1, 8'h41, 8'h00, 8'h40, 8'h41); step("after_abs");
        set_redirect(1, 2'b01, 8'hF0, 8'h20, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h10); step("relative");
        set_redirect(1, 2'b10, 8'h00, 8'h00, 8'h9A);
        push(0, 8'h00, 8'h00, 8'h00, 8'h9A); step("return");
        set_redirect(1, 2'b00, 8'h11, 8'h22, 8'h33);
        push(1, 8'h42, 8'h00, 8'h9A, 8'h9B); step("select_none");
        set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_stall_redirect();
        ifc.stall = 1'b1;
        set_redirect(1, 2'b11, 8'h00, 8'h55, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h55); step("redirect_over_stall");
        set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h55); step("stall_after_redirect");
        ifc.stall = 1'b0;
        push(0, 8'h00, 8'h00, 8'h00, 8'h56); step("od_bubble");
        ifc.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(0, 8'h00, 8'h00, 8'h00, 8'h56); step("stall_in_od");
        end
        ifc.stall = 1'b0;
        push(1, 8'h30, 8'h99, 8'h55, 8'h57); step("od_after_stall");
    endtask

    task automatic test_wrap();
        set_redirect(1, 2'b11, 8'h00, 8'hFF, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'hFF); step("jump_ff");
        set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h00); step("wrap_bubble");
        push(1, 8'h88, 8'h12, 8'hFF, 8'h01); step("wrap_emit");
        push(1, 8'h41, 8'h00, 8'h01, 8'h02); step("after_wrap");
    endtask

    task automatic test_classify();
        logic [7:0] ops [24] = '{8'h02, 8'h03, 8'h06, 8'h07, 8'h08, 8'h0F, 8'h10, 8'h27,
                                 8'h28, 8'h30, 8'h3F, 8'h40, 8'h57, 8'h58, 8'h60, 8'h80,
                                 8'h87, 8'h88, 8'h8F, 8'hE8, 8'hEF, 8'hF0, 8'hF8, 8'h9C};
        logic [7:0] lo [7] = '{8'h03, 8'h08, 8'h28, 8'h30, 8'h58, 8'h88, 8'h00};
        logic [7:0] hi [7] = '{8'h06, 8'h0F, 8'h2F, 8'h3F, 8'h5F, 8'h8F, 8'h00};
        foreach (ops[k]) begin
            logic two;
            two = 1'b0;
            for (int r = 0; r < 6; r++)
                if (ops[k] >= lo[r] && ops[k] <= hi[r]) two = 1'b1;
            for (int g = 1; g <= 6; g++)
                if (ops[k] >= 8'h88 + 8'(g * 16) && ops[k] <= 8'h8F + 8'(g * 16)) two = 1'b1;
            mem[8'h80] = ops[k];
            mem[8'h81] = 8'hA5;
            set_redirect(1, 2'b11, 8'h00, 8'h80, 8'h00);
            push(0, 8'h00, 8'h00, 8'h00, 8'h80); step("cls_jump");
            set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
            if (two) begin
                push(0, 8'h00, 8'h00, 8'h00, 8'h81); step("cls_two_bubble");
                push(1, ops[k], 8'hA5, 8'h80, 8'h82); step("cls_two_emit");
            end else begin
                push(1, ops[k], 8'h00, 8'h80, 8'h81); step("cls_one_emit");
            end
        end
    endtask

    task automatic test_reset_mid_od();
        set_redirect(1, 2'b11, 8'h00, 8'h02, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h02); step("pre_reset_jump");
        set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
        push(0, 8'h00, 8'h00, 8'h00, 8'h03); step("pre_reset_od");
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ifc.valid_out, ifc.opcode_out, ifc.operand_out, ifc.instr_pc, ifc.imem_addr} !== 33'h0)
            $display("FAIL async_reset: got v=%b op=%h od=%h pc=%h addr=%h, want all zero",
                     ifc.valid_out, ifc.opcode_out, ifc.operand_out, ifc.instr_pc, ifc.imem_addr);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ifc.valid_out !== 1'b0 || ifc.imem_addr !== 8'h00)
            $display("FAIL reset_held: got v=%b addr=%h, want v=0 addr=00", ifc.valid_out, ifc.imem_addr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        push(1, 8'h12, 8'h00, 8'h00, 8'h01); step("fetch_after_reset");
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'h01] = 8'h41; mem[8'h02] = 8'h5B; mem[8'h03] = 8'h7F;
        mem[8'h04] = 8'h41; mem[8'h05] = 8'h42; mem[8'h06] = 8'h88;
        mem[8'h40] = 8'h41; mem[8'h9A] = 8'h42;
        mem[8'h55] = 8'h30; mem[8'h56] = 8'h99;
        rst_n     = 1'b0;
        ifc.stall = 1'b0;
        set_redirect(0, 2'b00, 8'h00, 8'h00, 8'h00);
        #3;
        test_reset();
        test_two_byte();
        test_stall();
        test_redirect();
        test_stall_redirect();
        mem[8'hFF] = 8'h88; mem[8'h00] = 8'h12;
        test_wrap();
        test_classify();
        test_reset_mid_od();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL expose ports: clk  in  1  rising-edge clock, the only clock.
REQ-002 SHALL expose ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose imem_addr  out  8  instruction memory address, combinational copy of PC.
REQ-004 SHALL expose imem_data  in  8  instruction memory byte, valid in the same cycle as imem_addr.
REQ-005 SHALL expose stall  in  1  hold request from downstream.
REQ-006 SHALL expose L_PC  in  1  redirect strobe from control stage.
REQ-007 SHALL expose S11, S10  in  1 each  redirect source select: 01 relative, 11 absolute, 10 return, 00 none.
REQ-008 SHALL expose rd_base  in  8  instr_pc of the redirecting instruction; rd_od  in  8  its operand; rd_ret  in  8  popped return address.
REQ-009 SHALL expose opcode_out  out  8  opcode to control stage, registered.
REQ-010 SHALL expose operand_out  out  8  operand byte, registered.
REQ-011 SHALL expose instr_pc  out  8  address of the opcode byte, registered.
REQ-012 SHALL expose valid_out  out  1  opcode_out/operand_out/instr_pc form a real instruction.

Function
REQ-013 SHALL classify as 2-byte: 0x03, 0x04, 0x05, 0x06, 0000_1xxx, 0010_1xxx, 0011_0xxx, 0011_1xxx, 0101_1xxx, and 1000_1xxx through 1110_1xxx; all other opcodes SHALL be 1-byte.
REQ-014 SHALL implement states FETCH_OP and FETCH_OD; PC SHALL be 8 bits, incrementing modulo 256 (0xFF -> 0x00).
REQ-015 In FETCH_OP with a 1-byte opcode: at the clock edge SHALL register opcode_out=imem_data, operand_out=0x00, instr_pc=PC, valid_out=1, PC+1, remain in FETCH_OP.
REQ-016 In FETCH_OP with a 2-byte opcode: SHALL hold the opcode and its PC internally, PC+1, go to FETCH_OD, emit a bubble (valid_out=0, opcode_out=0x00, operand_out=0x00).
REQ-017 In FETCH_OD: SHALL register held opcode, operand_out=imem_data, instr_pc=held PC, valid_out=1, PC+1, return to FETCH_OP; latency from opcode byte to valid output is 2 cycles.
REQ-018 Every bubble SHALL drive opcode_out=0x00 (NOP) so the control stage decodes no action.
REQ-019 L_PC=1 with select 01 SHALL load PC=(rd_base+rd_od) mod 256; 11 SHALL load PC=rd_od; 10 SHALL load PC=rd_ret; 00 SHALL be treated as L_PC=0.
REQ-020 A redirect SHALL force state FETCH_OP, discard any held partial instruction, and emit a bubble on the same edge.
REQ-021 stall=1 without an effective redirect SHALL hold PC, state, held opcode and all outputs unchanged.
REQ-022 Redirect SHALL take priority over stall when both are asserted in the same cycle.
REQ-023 A 2-byte instruction at 0xFF SHALL take its operand from 0x00.
REQ-024 instr_pc SHALL wrap consistently with PC; no flags or error outputs exist.

Reset
REQ-025 rst_n=0 SHALL immediately, without clk, set PC=0x00, state=FETCH_OP, held opcode=0x00, opcode_out=0x00, operand_out=0x00, instr_pc=0x00, valid_out=0.
REQ-026 Assertion mid-FETCH_OD SHALL abandon the instruction; first fetch after release SHALL be from 0x00.
REQ-027 Release SHALL be sampled at a rising edge; the first edge with rst_n=1 performs a normal fetch of address 0x00.

Verification
REQ-028 Memory 0x00:0x00, 0x01:0x41; release reset -> edge1: opcode_out=0x00, instr_pc=0x00, valid=1; edge2: 0x41, instr_pc=0x01, valid=1.
REQ-029 Memory 0x02:0x5B, 0x03:0x7F -> edge at 0x02: valid=0, opcode_out=0x00; next edge: opcode_out=0x5B, operand_out=0x7F, instr_pc=0x02, valid=1; imem_addr=0x04.
REQ-030 In FETCH_OD, L_PC=1, S11S10=11, rd_od=0x40 -> next edge: valid=0, state FETCH_OP, imem_addr=0x40; held opcode never emitted.
REQ-031 L_PC=1, S11S10=01, rd_base=0xF0, rd_od=0x20 -> imem_addr=0x10; S11S10=10, rd_ret=0x9A -> imem_addr=0x9A.
REQ-032 stall=1 for 3 cycles mid-stream -> all outputs and imem_addr constant; stall=1 with L_PC=1, S11S10=11, rd_od=0x55 -> imem_addr=0x55 after one edge.
REQ-033 PC=0xFF holding 0x88, 0x00 holding 0x12 -> opcode_out=0x88, operand_out=0x12, instr_pc=0xFF; then imem_addr=0x01.
